// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial shift-register link: FSM encodings,
// shift-direction meaning and the bit-counter width helper.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit-position counter for the serializer; flags the final bit of a word.
module piso_serializer_bit_counter #(
    parameter int CNT_W = 3,
    parameter int N     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign terminal = (cnt == CNT_W'(N - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts a word on load/ready and emits
// it one bit per enabled clock, LSB- or MSB-first, with back-to-back words.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         load,
    input  logic         direction,
    input  logic [N-1:0] D,
    output logic         ready,
    output logic         Q,
    output logic         valid,
    output logic         last
);

    localparam int CNT_W = cnt_width(N);

    state_t       state;
    state_t       state_next;
    logic [N-1:0] shreg;
    logic         dir_q;
    logic         terminal;
    logic         accept;
    logic         advance;

    assign last    = (state == ST_SHIFT) && terminal;
    assign ready   = (state == ST_IDLE) || (last && enable);
    assign accept  = load && ready;
    assign advance = (state == ST_SHIFT) && enable && !last;

    piso_serializer_bit_counter #(
        .CNT_W (CNT_W),
        .N     (N)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .inc      (advance),
        .terminal (terminal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A load accepted on the final bit's edge chains straight into the next word.
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = ST_SHIFT;
        end else if (last && enable) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg <= '0;
            dir_q <= DIR_LSB_FIRST;
        end else if (accept) begin
            shreg <= D;
            dir_q <= direction;
        end else if (advance) begin
            shreg <= (dir_q == DIR_MSB_FIRST) ? (shreg << 1) : (shreg >> 1);
        end
    end

    assign valid = (state == ST_SHIFT);
    assign Q     = valid && ((dir_q == DIR_MSB_FIRST) ? shreg[N-1] : shreg[0]);

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized and directed bench for piso_serializer against a queue-based
// model of the bits still owed on the serial line.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic       direction = 1'b0;
    logic [7:0] D = 8'h00;
    logic       ready;
    logic       Q;
    logic       valid;
    logic       last;

    int n_checks = 0;
    int n_errors = 0;

    bit         pend[$];
    int         nvalid;
    int         nlast;
    logic [7:0] rx;
    logic       rx_dir;

    piso_serializer #(.N(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .direction (direction),
        .D         (D),
        .ready     (ready),
        .Q         (Q),
        .valid     (valid),
        .last      (last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle from just after a negedge; compare before the posedge,
    // then advance the model with what the edge should have done.
    task automatic cycle(input logic rst_n, input logic en, input logic ld,
                         input logic dr, input logic [7:0] d, input bit do_chk);
        logic exp_valid, exp_q, exp_last, exp_ready;
        reset = rst_n; enable = en; load = ld; direction = dr; D = d;
        #1;
        exp_valid = (pend.size() != 0);
        exp_q     = exp_valid ? pend[0] : 1'b0;
        exp_last  = (pend.size() == 1);
        exp_ready = !exp_valid || (exp_last && en);
        if (do_chk) begin
            chk("ready", {31'b0, ready}, {31'b0, exp_ready});
            chk("valid", {31'b0, valid}, {31'b0, exp_valid});
            chk("q",     {31'b0, Q},     {31'b0, exp_q});
            chk("last",  {31'b0, last},  {31'b0, exp_last});
        end
        if (valid === 1'b1) nvalid++;
        if (last === 1'b1) nlast++;
        if (valid === 1'b1 && en)
            rx = rx_dir ? {rx[6:0], Q} : {Q, rx[7:1]};
        @(posedge clk);
        if (!rst_n) begin
            pend.delete();
        end else begin
            if (en && pend.size() != 0) void'(pend.pop_front());
            if (ld && exp_ready) begin
                pend.delete();
                for (int i = 0; i < 8; i++)
                    pend.push_back(dr ? d[7-i] : d[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic clr_counts();
        nvalid = 0;
        nlast  = 0;
    endtask

    initial begin
        rx = 8'h00;
        rx_dir = 1'b0;
        clr_counts();
        @(negedge clk);

        // Reset held low two cycles with load requested
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'hC1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'hC1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // LSB-first 8'hC1
        clr_counts();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'hC1, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("lsb_valid_cnt", nvalid, 8);
        chk("lsb_last_cnt", nlast, 1);

        // MSB-first 8'hC1
        clr_counts();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'hC1, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("msb_valid_cnt", nvalid, 8);
        chk("msb_last_cnt", nlast, 1);

        // Stall for three cycles after two bits, toggling direction meanwhile
        clr_counts();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'hC1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, i[0], 8'hFF, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("stall_valid_cnt", nvalid, 11);
        chk("stall_last_cnt", nlast, 1);

        // load held high: two back-to-back words
        clr_counts();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'hC1, 1'b1);
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, (i == 8) ? 8'h0F : 8'hC1, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("b2b_valid_cnt", nvalid, 16);
        chk("b2b_last_cnt", nlast, 2);

        // Reset mid-word, then loop 8'h5A MSB-first into a serial-in receiver
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'hC1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'hC1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        rx = 8'h00;
        rx_dir = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("loopback_rx", {24'b0, rx}, 32'h5A);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 60) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
                  1'($urandom), 8'($urandom), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
